// File: rtl/ccd_reader.sv
// Read-domain client of ccd_register: strobes one read per word and queues the
// captured bytes in a first-word-fall-through FIFO for a valid/ready consumer.
module ccd_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk_out,
    input  logic                    reset,
    input  logic                    ccd_ready,
    input  logic [WIDTH-1:0]        ccd_dout,
    output logic                    ccd_re,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        rd_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StStrobe  = 2'd1;
    localparam logic [1:0] StWaitLow = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             re_q, re_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push, pop;

    // Space check uses the registered level only; a same-edge pop does not count.
    assign push = (state_q == StIdle) && ccd_ready && (level_q < LvlW'(DEPTH));
    assign pop  = m_valid && m_ready;

    always_comb begin
        state_d  = state_q;
        re_d     = push;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle:    if (push) state_d = StStrobe;
            StStrobe:  state_d = StWaitLow;
            StWaitLow: if (!ccd_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q  <= StIdle;
            re_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            re_q     <= re_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an empty FIFO masks stale contents on m_data.
    always_ff @(posedge clk_out) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= ccd_dout;
        end
    end

    assign ccd_re   = re_q;
    assign m_valid  = (level_q != '0);
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign rd_count = count_q;

endmodule

// File: tb/tb_ccd_reader.sv
// Directed bench for ccd_reader with DEPTH=4 and a 4-bit rd_count so the wrap is reachable.
module tb_ccd_reader;

    logic       clk_out = 1'b0;
    logic       reset;
    logic       ccd_ready;
    logic [7:0] ccd_dout;
    logic       ccd_re;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] level;
    logic [3:0] rd_count;

    int checks = 0;
    int errors = 0;

    logic       cap_en = 1'b0;
    logic [7:0] popped[$];
    int         pulses;

    ccd_reader #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
        .clk_out  (clk_out),
        .reset    (reset),
        .ccd_ready(ccd_ready),
        .ccd_dout (ccd_dout),
        .ccd_re   (ccd_re),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .rd_count (rd_count)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; records pops seen before the edge, counts ccd_re after it.
    task automatic step();
        if (cap_en && m_valid && m_ready) popped.push_back(m_data);
        @(posedge clk_out);
        #1;
        if (ccd_re) pulses++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ccd_ready = 1'b0;
        m_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Offer one word, wait for its strobe, then complete the ready handshake.
    task automatic write_word(input logic [7:0] d);
        int n;
        ccd_dout = d;
        ccd_ready = 1'b1;
        n = 0;
        pulses = 0;
        while (pulses == 0 && n < 20) begin
            step();
            n++;
        end
        if (pulses == 0) chk("write_timeout", 32'(n), 32'd0);
        ccd_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        ccd_ready = 1'b0;
        ccd_dout = 8'h00;
        m_ready = 1'b0;

        // 1. reset
        repeat (3) step();
        chk("rst_re", 32'(ccd_re), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_count", 32'(rd_count), 32'd0);
        reset = 1'b0;

        // 2. single word, held ready, second word
        ccd_dout = 8'hA5;
        ccd_ready = 1'b1;
        step();
        chk("t2_re", 32'(ccd_re), 32'd1);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data", 32'(m_data), 32'hA5);
        chk("t2_level", 32'(level), 32'd1);
        chk("t2_count", 32'(rd_count), 32'd1);
        pulses = 0;
        repeat (6) step();
        chk("t2_no_reread", 32'(pulses), 32'd0);
        ccd_ready = 1'b0;
        step();
        ccd_dout = 8'h3C;
        ccd_ready = 1'b1;
        step();
        chk("t2_re2", 32'(ccd_re), 32'd1);
        chk("t2_level2", 32'(level), 32'd2);
        chk("t2_data2", 32'(m_data), 32'hA5);
        chk("t2_count2", 32'(rd_count), 32'd2);
        step();
        chk("t2_re_drop", 32'(ccd_re), 32'd0);

        // 3. full / backpressure
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        write_word(8'h44);
        chk("t3_level_full", 32'(level), 32'd4);
        chk("t3_count4", 32'(rd_count), 32'd4);
        ccd_dout = 8'h55;
        ccd_ready = 1'b1;
        pulses = 0;
        repeat (5) step();
        chk("t3_held", 32'(pulses), 32'd0);
        chk("t3_head", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t3_pop_no_re", 32'(ccd_re), 32'd0);
        chk("t3_pop_level", 32'(level), 32'd3);
        chk("t3_pop_head", 32'(m_data), 32'h22);
        step();
        chk("t3_late_re", 32'(ccd_re), 32'd1);
        chk("t3_late_level", 32'(level), 32'd4);
        chk("t3_count5", 32'(rd_count), 32'd5);
        ccd_ready = 1'b0;
        step();
        step();
        m_ready = 1'b1;
        chk("t3_drain0", 32'(m_data), 32'h22);
        step();
        chk("t3_drain1", 32'(m_data), 32'h33);
        step();
        chk("t3_drain2", 32'(m_data), 32'h44);
        step();
        chk("t3_drain3", 32'(m_data), 32'h55);
        step();
        chk("t3_empty_valid", 32'(m_valid), 32'd0);
        chk("t3_empty_data", 32'(m_data), 32'd0);
        step();
        chk("t3_empty_pop_level", 32'(level), 32'd0);
        m_ready = 1'b0;

        // 4. simultaneous push and pop
        do_reset();
        write_word(8'h66);
        chk("t4_level1", 32'(level), 32'd1);
        ccd_dout = 8'h77;
        ccd_ready = 1'b1;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t4_re", 32'(ccd_re), 32'd1);
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_data", 32'(m_data), 32'h77);
        chk("t4_count", 32'(rd_count), 32'd2);
        ccd_ready = 1'b0;
        step();
        step();

        // 5. reset while waiting for ready to drop
        do_reset();
        ccd_dout = 8'h99;
        ccd_ready = 1'b1;
        step();
        chk("t5_re", 32'(ccd_re), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_level", 32'(level), 32'd0);
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_count", 32'(rd_count), 32'd0);
        chk("t5_rst_re", 32'(ccd_re), 32'd0);
        pulses = 0;
        step();
        chk("t5_new_re", 32'(ccd_re), 32'd1);
        chk("t5_data", 32'(m_data), 32'h99);
        chk("t5_count", 32'(rd_count), 32'd1);
        repeat (4) step();
        chk("t5_one_pulse", 32'(pulses), 32'd1);
        ccd_ready = 1'b0;
        step();

        // 6. rd_count wrap with continuous drain
        do_reset();
        m_ready = 1'b1;
        cap_en = 1'b1;
        for (int i = 0; i < 17; i++) write_word(8'(8'h40 + i));
        chk("t6_wrap_count", 32'(rd_count), 32'd1);
        repeat (3) step();
        cap_en = 1'b0;
        chk("t6_pop_total", 32'(popped.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < popped.size()) chk("t6_order", 32'(popped[i]), 32'(8'h40 + i));
        end
        chk("t6_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_reader.md
Name: ccd_reader

Overview:
- Read-side client of the ccd_register clock-domain-crossing register; lives entirely in the read (clk_out) domain.
- Watches the register's ready flag, issues one-cycle read strobes, captures each byte and queues it in a small first-word-fall-through FIFO.
- Presents the queued bytes downstream on a valid/ready stream.
- Guarantees exactly one read per word and applies backpressure by withholding reads while the FIFO is full.

Parameters:
WIDTH, 8, data width; must equal the ccd_register data width.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 16, width of the rd_count statistics counter.

Ports:
clk_out  in  1  read-domain clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ccd_ready  in  1  ready flag from ccd_register (read domain).
ccd_dout  in  WIDTH  data from ccd_register; stable while ccd_ready=1.
ccd_re  out  1  read strobe to ccd_register; registered; one-cycle pulse.
m_data  out  WIDTH  head-of-FIFO data.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  downstream accept; a pop occurs when m_valid && m_ready at an edge.
level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
rd_count  out  CNT_W  total words captured; wraps.

Behaviour:
- Reset is synchronous (sampled at a clk_out edge) and overrides everything.
  - State goes to IDLE.
  - ccd_re=0, FIFO empty (pointers 0), level=0, m_valid=0, m_data=0, rd_count=0.
  - FIFO contents need not be cleared.
- FSM states:
  - IDLE: at an edge with ccd_ready=1 and level<DEPTH, all of the following happen: ccd_re<=1, mem[wr_ptr]<=ccd_dout, wr_ptr++, level++, rd_count++; go to STROBE. Otherwise stay in IDLE.
  - STROBE: exactly one cycle; ccd_re<=0; go to WAIT_LOW.
  - WAIT_LOW: stay while ccd_ready=1; at the first edge with ccd_ready=0, go to IDLE.
- The WAIT_LOW hold prevents a second read of the same word, whatever the crossing latency between re and ready falling. ccd_re is never high on two consecutive cycles.
- Space check uses the registered level only. A pop on the same edge does not create space for a read on that edge.
- Latency:
  - ccd_re, m_valid (if the FIFO was empty) and the level increment all become visible after the same edge that sampled ccd_ready=1.
  - A pushed word is poppable on the following edge.
- FIFO:
  - First-word fall-through: m_data = mem[rd_ptr] when level!=0, otherwise 0.
  - m_valid = (level!=0).
  - Pointers are clog2(DEPTH) bits and wrap naturally.
- Pop and push on the same edge: both take effect and level is unchanged. This is legal at level=DEPTH only for the pop, because no push is allowed when full.
- Pop with m_valid=0 (m_ready high while empty): ignored, level stays 0.
- Full (level=DEPTH): no ccd_re is issued. The ccd_register word stays pending (its busy remains set upstream). The read happens at the first IDLE edge after level<DEPTH.
- rd_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation, in any state: the next state is IDLE and queued data is discarded. If ccd_ready is still 1 after reset, that word is treated as new and read; the system resets ccd_register and ccd_reader together, so this normally does not occur.
- ccd_ready falling while in IDLE without a read: no action.

Test Plan:
1. Reset: hold reset 3 edges with ccd_ready=0 -> ccd_re=0, m_valid=0, m_data=0, level=0, rd_count=0.
2. Single word: ccd_dout=8'hA5, ccd_ready=1, m_ready=0 -> exactly one ccd_re pulse; m_valid=1, m_data=A5, level=1, rd_count=1. Hold ccd_ready high 6 more cycles -> no further ccd_re. Drop ccd_ready, then raise it with 8'h3C -> second pulse, level=2, m_data still A5.
3. Full/backpressure (DEPTH=4): m_ready=0, offer 11,22,33,44,55 via the ready handshake -> 4 pulses, level=4. 55 is held with no ccd_re. Pulse m_ready for one cycle -> 11 popped, then ccd_re for 55 on the next IDLE edge. Draining yields 22,33,44,55 in order.
4. Simultaneous push/pop: level=1 (head 66), m_ready=1 on the same edge as a read of 77 -> level stays 1, m_data=77 next cycle, rd_count increments.
5. Reset in WAIT_LOW: after a read of 8'h99 with ccd_ready still high, assert reset for 1 edge -> level=0, m_valid=0, rd_count=0. After release with ccd_ready=1 -> one new ccd_re, m_data=99, rd_count=1.
6. Wrap: CNT_W=4, m_ready=1, stream 17 words -> rd_count reads 1 after the 17th word; no data lost, order preserved.
